// File: rtl/ocm_arbiter.sv
// ocm_arbiter
//   Shares one single-port on-chip memory (1-cycle read latency) between two
//   Avalon-MM masters. At most one transfer is granted per cycle. The granted
//   command is forwarded to the memory port combinationally, and read data is
//   steered back to the issuing master one cycle later with readdatavalid.
//
//   Build option (macro OCM_ARB_ROUND_ROBIN_EN):
//     defined   : round-robin arbitration; a locking master may keep the grant
//                 for up to MAX_HOLD regrants while the other master waits.
//     undefined : fixed priority, m0 wins contention; lock inputs are ignored.
//
//   Ports
//     clk, reset                   clock, asynchronous active-high reset
//     mN_address/byteenable/read/write/writedata/lock   master N command
//     mN_waitrequest               master N command stalled
//     mN_readdata/readdatavalid    master N read return
//     mem_address/byteenable/chipselect/write/writedata/clken  memory command
//     mem_readdata                 memory q, valid 1 cycle after address
module ocm_arbiter #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    logic       req0;
    logic       req1;
    logic       ready_q;
    logic       gnt_vld;
    master_e    gnt;
    logic       sel_read;
    logic       sel_write;
    logic [1:0] rd_pend_q;
    logic [1:0] rd_pend_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grants are suppressed for the first cycle after reset release.
    assign gnt_vld = ready_q & (req0 | req1);

`ifdef OCM_ARB_ROUND_ROBIN_EN
    master_e    last_grant_q;
    master_e    last_grant_d;
    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;
    logic       lock_last;

    assign lock_last = (last_grant_q == M1) ? m1_lock : m0_lock;

    always_comb begin
        gnt = M0;
        if (req0 && req1) begin
            if (lock_last && (hold_cnt_q < 8'(MAX_HOLD))) begin
                gnt = last_grant_q;
            end else begin
                gnt = (last_grant_q == M0) ? M1 : M0;
            end
        end else if (req1) begin
            gnt = M1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        hold_cnt_d   = '0;
        if (gnt_vld) begin
            last_grant_d = gnt;
            // Count only locked regrants that actually make the other master wait.
            if (req0 && req1 && (gnt == last_grant_q) && lock_last) begin
                hold_cnt_d = (hold_cnt_q < 8'(MAX_HOLD)) ? hold_cnt_q + 8'd1 : hold_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= M1;
            hold_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = m0_lock ^ m1_lock;

    always_comb begin
        gnt = req0 ? M0 : M1;
    end
`endif

    always_comb begin
        if (gnt == M1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            sel_read       = m1_read;
            sel_write      = m1_write;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            sel_read       = m0_read;
            sel_write      = m0_write;
        end
    end

    assign mem_chipselect = gnt_vld;
    assign mem_write      = gnt_vld & sel_write;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = ~(gnt_vld && (gnt == M0));
    assign m1_waitrequest = ~(gnt_vld && (gnt == M1));

    // Write wins when read and write are both set, so no read return is tracked.
    always_comb begin
        rd_pend_d = '0;
        if (gnt_vld && sel_read && !sel_write) begin
            rd_pend_d = (gnt == M1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rd_pend_q <= '0;
        end else begin
            ready_q   <= 1'b1;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign m0_readdatavalid = rd_pend_q[0];
    assign m1_readdatavalid = rd_pend_q[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_ocm_arbiter.sv
// Bench for ocm_arbiter: a behavioural 8192x32 memory with registered q, an
// arbitration reference model, and per-master read scoreboards. Expected
// reads are queued at grant and popped when readdatavalid is expected.
module tb_ocm_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m1_read = 1'b0;
    logic        m0_write = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    always #5 clk = ~clk;

    ocm_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Memory: registered read of the presented address, byte-enabled write.
    logic [31:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_clken) begin
            mem_readdata <= ram[mem_address];
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] shadow [0:8191];
    logic [31:0] sbq0 [$];
    logic [31:0] sbq1 [$];
    logic        exp_ready, exp_last;
    int          exp_hold;
    logic [1:0]  exp_pend;
    logic        gv, g, cr0, cr1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_ready = 1'b0;
        exp_last  = 1'b1;
        exp_hold  = 0;
        exp_pend  = '0;
        sbq0.delete();
        sbq1.delete();
    endtask

    // Predicts this cycle's grant and checks all DUT outputs against it.
    task automatic check_cycle();
        logic lk, w, r;
        cr0 = m0_read | m0_write;
        cr1 = m1_read | m1_write;
        gv  = exp_ready && !reset && (cr0 || cr1);
        lk  = exp_last ? m1_lock : m0_lock;
        if (cr0 && cr1) begin
`ifdef OCM_ARB_ROUND_ROBIN_EN
            if (lk && exp_hold < MAX_HOLD) g = exp_last;
            else g = ~exp_last;
`else
            g = 1'b0;
`endif
        end else begin
            g = cr1;
        end
        w = g ? m1_write : m0_write;
        r = g ? m1_read : m0_read;
        check("m0_waitrequest", m0_waitrequest, !(gv && !g));
        check("m1_waitrequest", m1_waitrequest, !(gv && g));
        check("mem_chipselect", mem_chipselect, gv);
        check("mem_write", mem_write, gv && w);
        check("mem_clken", mem_clken, !reset);
        if (gv) begin
            check("mem_address", mem_address, g ? m1_address : m0_address);
            if (w) begin
                check("mem_byteenable", mem_byteenable, g ? m1_byteenable : m0_byteenable);
                check("mem_writedata", mem_writedata, g ? m1_writedata : m0_writedata);
            end
        end
        check("m0_readdatavalid", m0_readdatavalid, exp_pend[0]);
        check("m1_readdatavalid", m1_readdatavalid, exp_pend[1]);
        if (exp_pend[0] && sbq0.size() > 0) check("m0_readdata", m0_readdata, sbq0.pop_front());
        if (exp_pend[1] && sbq1.size() > 0) check("m1_readdata", m1_readdata, sbq1.pop_front());
        if (r && !w) ; // read return data is scheduled in update_model
    endtask

    // Applies the clock edge to the model.
    task automatic update_model();
        logic        w, r, lk;
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        if (reset) begin
            model_reset();
            return;
        end
        w  = g ? m1_write : m0_write;
        r  = g ? m1_read : m0_read;
        lk = g ? m1_lock : m0_lock;
        a  = g ? m1_address : m0_address;
        d  = g ? m1_writedata : m0_writedata;
        be = g ? m1_byteenable : m0_byteenable;
        exp_pend = '0;
        if (gv) begin
            if (r && !w) begin
                if (g) sbq1.push_back(shadow[a]);
                else   sbq0.push_back(shadow[a]);
                exp_pend[g] = 1'b1;
            end
            if (w)
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
            if (cr0 && cr1 && g == exp_last && lk) begin
                if (exp_hold < MAX_HOLD) exp_hold++;
            end else begin
                exp_hold = 0;
            end
            exp_last = g;
        end else begin
            exp_hold = 0;
        end
        exp_ready = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        logic hold0, hold1;
        model_reset();
        for (int i = 0; i < 8192; i++) ram[i] = 32'(i) ^ 32'h5A5A_0000;
        ram[0]    = 32'h1111_0000;
        ram[1]    = 32'h2222_1111;
        ram[16]   = 32'hDEAD_BEEF;
        ram[8191] = 32'hAABB_CCDD;
        for (int i = 0; i < 8192; i++) shadow[i] = ram[i];

        // Reset state, then m0 read of the preloaded word right after release.
        repeat (2) step();
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 13'h0010;
        step();
        step();
        m0_read = 1'b0;
        step();

        // Continuous writes from both masters; data advances only once granted.
        m0_write = 1'b1; m0_address = 13'h0100; m0_byteenable = 4'hF; m0_writedata = 32'h1000_0000;
        m1_write = 1'b1; m1_address = 13'h0200; m1_byteenable = 4'hF; m1_writedata = 32'h2000_0000;
        repeat (8) begin
            step();
            if (gv && !g) m0_writedata++;
            if (gv && g)  m1_writedata++;
        end
        m0_write = 1'b0;
        step();
        m1_write = 1'b0;
        step();

        // Partial-byte write then read-after-write from the other master.
        m1_write = 1'b1; m1_address = 13'h1FFF; m1_byteenable = 4'h3; m1_writedata = 32'h1234_5678;
        step();
        m1_write = 1'b0;
        m0_read = 1'b1; m0_address = 13'h1FFF;
        step();
        m0_read = 1'b0;
        step();

        // Locked m0 against a continuously requesting m1.
        m0_read = 1'b1; m0_address = 13'h0020; m0_lock = 1'b1;
        m1_read = 1'b1; m1_address = 13'h0021;
        repeat (24) step();
        m0_lock = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
        step();

        // Alternating reads: valid must alternate with no bubble.
        repeat (8) begin
            m0_read = 1'b1; m0_address = 13'h0000; m1_read = 1'b0;
            step();
            m0_read = 1'b0; m1_read = 1'b1; m1_address = 13'h0001;
            step();
        end
        m1_read = 1'b0;
        repeat (2) step();

        // Mixed random traffic; a stalled master holds its command.
        hold0 = 1'b0; hold1 = 1'b0;
        repeat (200) begin
            if (!hold0) begin
                m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
                m0_address = 13'($urandom_range(0, 7)); m0_byteenable = 4'($urandom);
                m0_writedata = $urandom; m0_lock = 1'($urandom_range(0, 1));
            end
            if (!hold1) begin
                m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
                m1_address = 13'($urandom_range(0, 7)); m1_byteenable = 4'($urandom);
                m1_writedata = $urandom; m1_lock = 1'($urandom_range(0, 1));
            end
            step();
            hold0 = cr0 && !(gv && !g);
            hold1 = cr1 && !(gv && g);
        end
        m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
        repeat (2) step();

        // Reset asserted the cycle after an m1 read grant drops the return.
        m1_read = 1'b1; m1_address = 13'h0001;
        step();
        reset = 1'b1;
        model_reset();
        #1;
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
        m1_read = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ocm_arbiter.md
# ocm_arbiter

Two-master arbiter that shares the single-port 32-bit x 8192-word on-chip memory between two Avalon-MM masters, typically the Nios II data master and a DMA or custom accelerator. It grants at most one transfer per cycle, forwards the command to the memory port, and routes the 1-cycle-latency read data back to the issuing master with `readdatavalid`. Round-robin with optional lock; fixed priority when the round-robin feature is compiled out.

## Interface
- `ADDR_W`, 13: word address width, matching the memory's `address`.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `MAX_HOLD`, 8: maximum consecutive locked grants to one master while the other is requesting (1..255).

Ports:
- `clk` in 1: single clock for the block and the memory.
- `reset` in 1: asynchronous, active-high.
- `m0_address` / `m1_address` in ADDR_W: word address.
- `m0_byteenable` / `m1_byteenable` in 4: byte lanes.
- `m0_read` / `m1_read` in 1: read request.
- `m0_write` / `m1_write` in 1: write request.
- `m0_writedata` / `m1_writedata` in 32: write data.
- `m0_lock` / `m1_lock` in 1: request to retain the grant.
- `m0_waitrequest` / `m1_waitrequest` out 1: command stalled.
- `m0_readdata` / `m1_readdata` out 32: read data.
- `m0_readdatavalid` / `m1_readdatavalid` out 1: read data valid.
- `mem_address` out ADDR_W, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32: memory command.
- `mem_clken` out 1: tied 1 while not in reset.
- `mem_readdata` in 32: memory `q`, valid 1 cycle after the address is presented.

## Operation
- Request: `mN_req = mN_read | mN_write`. If both are set, the transfer is a write and produces no `readdatavalid`.
- Grant is combinational each cycle from `req` and the registered state `last_grant` and `hold_cnt`:
  - One requester: that master is granted.
  - Both request, locked case: if `last_grant`'s master has its `lock` high and `hold_cnt < MAX_HOLD`, it keeps the grant.
  - Both request, otherwise: the master other than `last_grant` is granted.
- Granted master: `waitrequest=0`, and its command drives `mem_*` with `mem_chipselect=1`. The non-granted requester sees `waitrequest=1` and must hold its command. With no requester, `mem_chipselect=0` and `mem_write=0`.
- `last_grant` updates to the granted master on every grant and holds when idle.
- `hold_cnt`:
  - Increments when the same master is regranted while the other is requesting.
  - Clears on a switch, when the other master is not requesting, or when `lock` is low.
  - Saturates at `MAX_HOLD`.
- Read tracking register `rd_pend[1:0]` is set to the one-hot of the master granted for a read, else 0. `mN_readdatavalid = rd_pend[N]`. `mN_readdata = mem_readdata` for both masters; consumers qualify it with valid.
- Waitrequest behaviour outside reset:
  - `waitrequest` is high for a non-requesting master.
  - `waitrequest` is forced high for both masters during the first cycle after reset release, via the `ready` register.

## Timing
- Reset values:
  - `last_grant=1`, so m0 wins the first contention.
  - `hold_cnt=0`, `rd_pend=0`, `ready=0`.
  - Both `waitrequest=1`, both `readdatavalid=0`.
  - `mem_chipselect=0`, `mem_write=0`, `mem_clken=0`.
- Cycle T grant leads to the memory command in cycle T and `readdatavalid` in T+1. Write completes at the T clock edge.
- Throughput is one transfer per cycle. Back-to-back reads from alternating masters yield `readdatavalid` on alternating masters with no bubble.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset asserted mid-read clears `rd_pend` immediately; the pending read data is dropped, with no valid.
- `ready` rises on the first clock edge after reset deasserts. The first grant occurs at the earliest on that edge + 1 cycle.

## Configuration
- `OCM_ARB_ROUND_ROBIN_EN` defined: round-robin and lock behaviour as above.
- `OCM_ARB_ROUND_ROBIN_EN` undefined: fixed priority.
  - m0 always wins contention.
  - `lock` inputs and `hold_cnt` are ignored and removed.
  - `last_grant` is unused.
  - All other timing is unchanged.

## Test plan
- Reset release, m0 reads addr 0x0010 (preloaded 0xDEADBEEF) → `m0_waitrequest=0` from cycle 2 after reset, `m0_readdatavalid=1` next cycle with 0xDEADBEEF.
- m0 and m1 write continuously (addr 0x100 / 0x200) → grants alternate m0, m1, m0…; each master has `waitrequest=1` every other cycle. Under fixed priority, m1 is starved until m0 drops its request.
- m1 write 0x12345678 to 0x1FFF with byteenable 0x3, then m0 read 0x1FFF on the next cycle → m0 gets 0x????5678 (upper bytes keep prior value), valid 1 cycle after grant.
- m0 `lock=1` with continuous reads, m1 requesting, `MAX_HOLD=8` → m0 granted 9 consecutive cycles (the initial grant plus 8 regrants), then m1 granted once, then m0 resumes.
- m0 and m1 alternating reads of 0x0000/0x0001 → `readdatavalid` alternates between m0 and m1 every cycle with the correct data, no bubble.
- Reset asserted the cycle after an m1 read grant → `m1_readdatavalid` stays 0 and all outputs go to their reset values immediately (asynchronous).
